// File: rtl/mont_mul.sv
// Bit-serial radix-2 Montgomery multiplier: result = a*b*2^(-WIDTH) mod n.
// Optional operand check compiled in with `define MONT_MUL_OPCHK_EN.
module mont_mul #(
   parameter int unsigned WIDTH = 2048
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] n,
   input  logic             mul_start,
   output logic [WIDTH-1:0] result,
   output logic             mul_finish,
   output logic             mul_busy,
   output logic             mul_err
);

   localparam int unsigned IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [IW-1:0] I_LAST = IW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, CALC, SUB, DONE} state_t;

   state_t           state, state_nx;
   logic [WIDTH-1:0] a_q, b_q, n_q;
   logic [WIDTH+1:0] s, s1, s2;
   logic [WIDTH-1:0] s_red;
   logic [IW-1:0]    idx;
   logic             op_bad;

`ifdef MONT_MUL_OPCHK_EN
   assign op_bad = ~n[0] | (a >= n) | (b >= n);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         mul_err <= 1'b0;
      else if (state == IDLE && mul_start)
         mul_err <= op_bad;
      else if (state == DONE && !mul_start)
         mul_err <= 1'b0;
   end
`else
   assign op_bad  = 1'b0;
   assign mul_err = 1'b0;
`endif

   // S stays below 2n, so S + b + n fits in WIDTH+2 bits.
   always_comb begin
      s1    = s + (a_q[idx] ? {2'b00, b_q} : '0);
      s2    = s1 + (s1[0] ? {2'b00, n_q} : '0);
      s_red = s[WIDTH-1:0] - n_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE: if (mul_start) state_nx = op_bad ? DONE : CALC;
         CALC: begin
            if (!mul_start)           state_nx = IDLE;
            else if (idx == I_LAST)   state_nx = SUB;
         end
         SUB:  state_nx = mul_start ? DONE : IDLE;
         DONE: if (!mul_start) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q        <= '0;
         b_q        <= '0;
         n_q        <= '0;
         s          <= '0;
         idx        <= '0;
         result     <= '0;
         mul_finish <= 1'b0;
         mul_busy   <= 1'b0;
      end else begin
         mul_busy <= (state_nx == CALC) || (state_nx == SUB);
         case (state)
            IDLE: if (mul_start) begin
               a_q <= a;
               b_q <= b;
               n_q <= n;
               s   <= '0;
               idx <= '0;
               if (op_bad) begin
                  result     <= '0;
                  mul_finish <= 1'b1;
               end
            end
            CALC: if (mul_start) begin
               s   <= s2 >> 1;
               idx <= idx + 1'b1;
            end
            SUB: if (mul_start) begin
               result     <= (s >= {2'b00, n_q}) ? s_red : s[WIDTH-1:0];
               mul_finish <= 1'b1;
            end
            DONE: if (!mul_start) mul_finish <= 1'b0;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mont_mul.sv
// Self-checking bench for mont_mul at WIDTH = 8: directed table, corner sequences, random vs. reference.
module tb_mont_mul;

   localparam int unsigned W = 8;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [W-1:0] a = '0, b = '0, n = '0;
   logic         mul_start = 1'b0;
   logic [W-1:0] result;
   logic         mul_finish, mul_busy, mul_err;

   int n_cmp = 0;
   int n_bad = 0;

   mont_mul #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .a(a), .b(b), .n(n), .mul_start(mul_start),
      .result(result), .mul_finish(mul_finish), .mul_busy(mul_busy), .mul_err(mul_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] a, b, n, res;
   } vec_t;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   // Reference: the unique x in [0,n) with x*2^W == a*b (mod n).
   function automatic int ref_mont(input int ra, input int rb, input int rn);
      int p = (ra * rb) % rn;
      for (int x = 0; x < rn; x++)
         if (((x << W) % rn) == p) return x;
      return -1;
   endfunction

   // Starts an operation and waits for mul_finish; lat counts edges after the start edge.
   task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic [W-1:0] tn,
                         input bit scramble, output int lat, output int busy_cnt);
      @(negedge clk);
      a = ta; b = tb_; n = tn; mul_start = 1'b1;
      lat = 0; busy_cnt = 0;
      @(posedge clk); #1;
      if (mul_busy) busy_cnt++;
      if (scramble) begin
         a = W'($urandom); b = W'($urandom); n = W'($urandom);
      end
      for (int c = 0; c < 40; c++) begin
         if (mul_finish) break;
         @(posedge clk); #1;
         lat++;
         if (mul_busy) busy_cnt++;
      end
      if (!mul_finish) chk("finish_timeout", 32'(mul_finish), 1);
   endtask

   task automatic release_op(input logic [W-1:0] held);
      @(negedge clk);
      mul_start = 1'b0;
      @(posedge clk); #1;
      chk("finish_drop", 32'(mul_finish), 0);
      chk("result_kept", 32'(result), 32'(held));
   endtask

   vec_t vecs[5];
   int   lat, bcnt;
   logic [W-1:0] prev;

   initial begin
      vecs[0] = '{a: 8'd5,   b: 8'd7,   n: 8'd13,  res: 8'd1};
      vecs[1] = '{a: 8'd1,   b: 8'd1,   n: 8'd13,  res: 8'd3};
      vecs[2] = '{a: 8'd0,   b: 8'd9,   n: 8'd13,  res: 8'd0};
      vecs[3] = '{a: 8'd254, b: 8'd254, n: 8'd255, res: 8'd1};
      vecs[4] = '{a: 8'd12,  b: 8'd12,  n: 8'd13,  res: 8'd3};

      #1;
      chk("rst_result", 32'(result), 0);
      chk("rst_finish", 32'(mul_finish), 0);
      chk("rst_busy", 32'(mul_busy), 0);
      chk("rst_err", 32'(mul_err), 0);
      #20 rst_n = 1'b1;

      foreach (vecs[i]) begin
         run_op(vecs[i].a, vecs[i].b, vecs[i].n, 1'b0, lat, bcnt);
         chk("vec_result", 32'(result), 32'(vecs[i].res));
         chk("vec_latency", 32'(lat), W + 1);
         chk("vec_busy_cycles", 32'(bcnt), W + 1);
         chk("vec_err", 32'(mul_err), 0);
         release_op(vecs[i].res);
      end

      // Finish must hold while start stays high.
      run_op(8'd3, 8'd4, 8'd13, 1'b0, lat, bcnt);
      for (int c = 0; c < 3; c++) begin
         @(posedge clk); #1;
         chk("hold_finish", 32'(mul_finish), 1);
         chk("hold_result", 32'(result), 32'(ref_mont(3, 4, 13)));
      end
      release_op(W'(ref_mont(3, 4, 13)));

      // Abort 4 cycles into CALC.
      prev = result;
      @(negedge clk);
      a = 8'd6; b = 8'd11; n = 8'd13; mul_start = 1'b1;
      repeat (5) @(posedge clk);
      @(negedge clk);
      mul_start = 1'b0;
      for (int c = 0; c < 15; c++) begin
         @(posedge clk); #1;
         if (mul_finish !== 1'b0 || result !== prev) begin
            chk("abort_quiet", {mul_finish, 7'd0, result}, {1'b0, 7'd0, prev});
            break;
         end
      end
      chk("abort_busy", 32'(mul_busy), 0);
      chk("abort_result", 32'(result), 32'(prev));
      run_op(8'd5, 8'd7, 8'd13, 1'b0, lat, bcnt);
      chk("restart_result", 32'(result), 1);
      chk("restart_latency", 32'(lat), W + 1);
      release_op(8'd1);

      // Asynchronous reset during CALC.
      @(negedge clk);
      a = 8'd9; b = 8'd10; n = 8'd11; mul_start = 1'b1;
      repeat (4) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_result", 32'(result), 0);
      chk("arst_busy", 32'(mul_busy), 0);
      chk("arst_finish", 32'(mul_finish), 0);
      chk("arst_err", 32'(mul_err), 0);
      @(negedge clk);
      mul_start = 1'b0;
      rst_n = 1'b1;
      run_op(8'd9, 8'd10, 8'd11, 1'b0, lat, bcnt);
      chk("post_rst_result", 32'(result), 32'(ref_mont(9, 10, 11)));
      chk("post_rst_latency", 32'(lat), W + 1);
      release_op(W'(ref_mont(9, 10, 11)));

      // Even modulus.
      run_op(8'd5, 8'd7, 8'd12, 1'b0, lat, bcnt);
`ifdef MONT_MUL_OPCHK_EN
      chk("opchk_err", 32'(mul_err), 1);
      chk("opchk_result", 32'(result), 0);
      chk("opchk_latency", 32'(lat), 0);
      chk("opchk_busy", 32'(bcnt), 0);
      release_op(8'd0);
      chk("opchk_err_clear", 32'(mul_err), 0);
`else
      chk("nochk_err", 32'(mul_err), 0);
      chk("nochk_latency", 32'(lat), W + 1);
      @(negedge clk);
      mul_start = 1'b0;
      @(posedge clk); #1;
      chk("nochk_finish_drop", 32'(mul_finish), 0);
`endif

      // Random operands, inputs scrambled after the start edge.
      for (int t = 0; t < 40; t++) begin
         int rn, ra, rb, exp;
         rn = 2 * $urandom_range(1, 127) + 1;
         ra = $urandom_range(0, rn - 1);
         rb = $urandom_range(0, rn - 1);
         exp = ref_mont(ra, rb, rn);
         run_op(W'(ra), W'(rb), W'(rn), 1'b1, lat, bcnt);
         chk("rand_result", 32'(result), 32'(exp));
         chk("rand_latency", 32'(lat), W + 1);
         release_op(W'(exp));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/mont_mul.md
# mont_mul

Bit-serial radix-2 Montgomery multiplier computing `a·b·2^(-WIDTH) mod n` for odd modulus `n`. It is the datapath stage directly upstream of the Montgomery reduction block in the RSA modular-exponentiation chain, and feeds it Montgomery-domain products. It uses the same level-held start/finish handshake as the reduction stage, so the exponentiation controller can sequence both stages identically.

## Interface
- `WIDTH`, default 2048: operand, modulus and result width in bits. Minimum 4.
- `clk` input 1: clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `a` input WIDTH: multiplicand. Must satisfy `a < n`. Sampled on the start cycle.
- `b` input WIDTH: multiplier. Must satisfy `b < n`. Sampled on the start cycle.
- `n` input WIDTH: odd modulus. Sampled on the start cycle.
- `mul_start` input 1: level request. Held high for the whole operation.
- `result` output WIDTH: product. Valid while `mul_finish` = 1.
- `mul_finish` output 1: result valid. Held until `mul_start` drops.
- `mul_busy` output 1: high in CALC and SUB.
- `mul_err` output 1: operand error; see Configuration.

## Operation
- **States:**
  - IDLE: reset state. On `mul_start` = 1:
    - latch `a`, `b`, `n`;
    - clear accumulator S (WIDTH+2 bits) and the bit index `i` (clog2(WIDTH) bits);
    - go to CALC.
  - CALC: one iteration per cycle, bit `a[i]` for i = 0..WIDTH-1:
    - S1 = S + (a[i] ? b : 0);
    - S2 = S1 + (S1[0] ? n : 0);
    - S = S2 >> 1.
    - After the i = WIDTH-1 iteration, go to SUB. Otherwise increment i.
  - SUB: write `result` = (S ≥ n) ? S − n : S, truncated to WIDTH bits, with S < 2n guaranteed. Set `mul_finish` = 1 and go to DONE.
  - DONE: hold `result` and `mul_finish`. When `mul_start` = 0, clear `mul_finish` and go to IDLE. `result` keeps its value.
- **Abort:** `mul_start` = 0 in CALC or SUB returns to IDLE. `mul_finish` stays 0 and `result` is unchanged.
- **Operand changes:** `a`, `b`, `n` changing after the start cycle have no effect; only the latched copies are used.
- **Restart:** a new operation requires `mul_start` to be low for at least one cycle. Re-asserting it in DONE without a low cycle does nothing.
- **Reset:** `rst_n` low at any time, including mid-CALC:
  - state → IDLE;
  - `result` = 0, `mul_finish` = 0, `mul_busy` = 0, `mul_err` = 0;
  - S = 0, i = 0.
- **Out-of-range operands (no check compiled in):** if `n` is even or `a`/`b` ≥ n, the result is undefined but the timing is unchanged.

## Timing
- `mul_start` first seen high at edge k (IDLE → CALC).
- Edges k+1 … k+WIDTH perform the iterations. `mul_busy` is high after edge k and stays high until edge k+WIDTH+1.
- Edge k+WIDTH+1 (SUB → DONE): `result` valid and `mul_finish` = 1.
- Latency from the start edge to `mul_finish` is WIDTH+1 cycles (2049 cycles at the default width).
- `mul_finish` falls on the first edge at which `mul_start` is sampled low in DONE.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Configuration
- **Macro:** `MONT_MUL_OPCHK_EN`.
- **Defined:** in IDLE on start, check the operands. If `n[0]` = 0, or `a` ≥ `n`, or `b` ≥ `n`:
  - go straight to DONE;
  - `result` = 0, `mul_err` = 1, `mul_finish` = 1 after that single edge;
  - `mul_busy` never rises.
  - `mul_err` clears together with `mul_finish`.
- **Not defined:** no comparators are built and `mul_err` is tied to 0.

## Test plan
All scenarios use WIDTH = 8.
- **Basic product:** a = 5, b = 7, n = 13, start held → `result` = 1, `mul_finish` rises exactly 9 cycles after the start edge, `mul_busy` high for 9 cycles.
- **Identity and zero:** a = 1, b = 1, n = 13 → `result` = 3. Then a = 0, b = 9, n = 13 → `result` = 0.
- **Final subtraction path:** a = 254, b = 254, n = 255 → `result` = 1. Also check that `mul_finish` stays high while start stays high, and drops one edge after start goes low.
- **Abort:** deassert start 4 cycles into CALC → `mul_finish` never rises and `result` keeps its previous value. Restart with a = 5, b = 7, n = 13 → `result` = 1 after 9 cycles.
- **Reset mid-operation:** drive `rst_n` low during CALC → all outputs 0 immediately (asynchronous), state returns to IDLE. Then a clean run gives the correct result.
- **Operand check (macro defined):** n = 12 → `mul_err` = 1, `result` = 0, `mul_finish` one cycle after start. With the macro undefined, `mul_err` stays 0 and latency is 9 cycles.
